// File: rtl/fbcpu_core_v2.sv
// fbcpu_core_v2 : second-generation FB-CPU accumulator core.
// Multi-cycle FETCH/LATCH/DECODE/EXEC machine on a single-port RAM interface,
// with a resumable HALT state and sticky illegal-opcode / divide-by-zero flags.
// Optional feature macro: FBCPU_DIV_EN (defined = hardware divider for opcode 5,
// undefined = opcode 5 traps as illegal and div0 is tied low).
module fbcpu_core_v2 #(
   parameter int ADDRESS_WIDTH = 6,
   parameter int DATA_WIDTH    = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [DATA_WIDTH-1:0]    MDROut,
   output logic [ADDRESS_WIDTH-1:0] MAR,
   output logic [DATA_WIDTH-1:0]    MDRIn,
   output logic                     RAMWr,
   output logic [ADDRESS_WIDTH-1:0] PC,
   output logic [DATA_WIDTH-1:0]    ACC,
   output logic                     carry,
   output logic                     halted,
   output logic                     illegal,
   output logic                     div0
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_LATCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_HALT   = 3'd4;

   localparam logic [3:0] OP_LOAD  = 4'd0;
   localparam logic [3:0] OP_STORE = 4'd1;
   localparam logic [3:0] OP_ADD   = 4'd2;
   localparam logic [3:0] OP_SUB   = 4'd3;
   localparam logic [3:0] OP_MUL   = 4'd4;
   localparam logic [3:0] OP_DIV   = 4'd5;
   localparam logic [3:0] OP_JMP   = 4'd6;
   localparam logic [3:0] OP_JZ    = 4'd7;
   localparam logic [3:0] OP_NOP   = 4'd8;
   localparam logic [3:0] OP_HALT  = 4'd9;
   localparam logic [3:0] OP_AND   = 4'd10;
   localparam logic [3:0] OP_OR    = 4'd11;
   localparam logic [3:0] OP_JC    = 4'd12;
   localparam logic [3:0] OP_JN    = 4'd13;
   localparam logic [3:0] OP_LDI   = 4'd14;
   localparam logic [3:0] OP_ILL   = 4'd15;

   logic [2:0]               state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0]    ir_q, ir_d;
   logic [DATA_WIDTH-1:0]    acc_q, acc_d;
   logic                     carry_q, carry_d;
   logic                     ill_q, ill_d;
`ifdef FBCPU_DIV_EN
   logic                     div0_q, div0_d;
`endif

   logic [3:0]               opcode;
   logic [ADDRESS_WIDTH-1:0] operand;

   assign opcode  = ir_q[DATA_WIDTH-1 -: 4];
   assign operand = ir_q[ADDRESS_WIDTH-1:0];

   assign PC      = pc_q;
   assign ACC     = acc_q;
   assign carry   = carry_q;
   assign illegal = ill_q;
   assign halted  = (state_q == S_HALT);
`ifdef FBCPU_DIV_EN
   assign div0    = div0_q;
`else
   assign div0    = 1'b0;
`endif

   // Next-state, datapath and RAM-strobe decode for the multi-cycle sequence.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      acc_d   = acc_q;
      carry_d = carry_q;
      ill_d   = ill_q;
`ifdef FBCPU_DIV_EN
      div0_d  = div0_q;
`endif
      MAR     = '0;
      MDRIn   = '0;
      RAMWr   = 1'b0;
      case (state_q)
         S_FETCH: begin
            MAR     = pc_q;
            state_d = S_LATCH;
         end
         S_LATCH: begin
            ir_d    = MDROut;
            pc_d    = pc_q + 1'b1;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            state_d = S_FETCH;
            case (opcode)
               OP_LOAD, OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR: begin
                  MAR     = operand;
                  state_d = S_EXEC;
               end
               OP_DIV: begin
`ifdef FBCPU_DIV_EN
                  MAR     = operand;
                  state_d = S_EXEC;
`else
                  ill_d   = 1'b1;
                  state_d = S_HALT;
`endif
               end
               OP_STORE: begin
                  MAR   = operand;
                  MDRIn = acc_q;
                  RAMWr = 1'b1;
               end
               OP_JMP: pc_d = operand;
               OP_JZ:  if (acc_q == '0) pc_d = operand;
               OP_JC:  if (carry_q) pc_d = operand;
               OP_JN:  if (acc_q[DATA_WIDTH-1]) pc_d = operand;
               OP_NOP: ;
               OP_HALT: state_d = S_HALT;
               OP_LDI: acc_d = {{(DATA_WIDTH-ADDRESS_WIDTH){1'b0}}, operand};
               OP_ILL: begin
                  ill_d   = 1'b1;
                  state_d = S_HALT;
               end
               default: ;
            endcase
         end
         S_EXEC: begin
            state_d = S_FETCH;
            case (opcode)
               OP_LOAD: acc_d = MDROut;
               OP_ADD:  {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, MDROut};
               OP_SUB: begin
                  acc_d   = acc_q - MDROut;
                  carry_d = (acc_q < MDROut);
               end
               // Truncated product: only the low word is kept.
               OP_MUL:  acc_d = acc_q * MDROut;
`ifdef FBCPU_DIV_EN
               OP_DIV: begin
                  if (MDROut == '0) begin
                     acc_d  = '1;
                     div0_d = 1'b1;
                  end else begin
                     acc_d  = acc_q / MDROut;
                  end
               end
`endif
               OP_AND:  acc_d = acc_q & MDROut;
               OP_OR:   acc_d = acc_q | MDROut;
               default: ;
            endcase
         end
         S_HALT: if (start) state_d = S_FETCH;
         default: state_d = S_FETCH;
      endcase
   end

   // Architectural registers; async reset returns the core to FETCH at address 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         ill_q   <= 1'b0;
`ifdef FBCPU_DIV_EN
         div0_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         acc_q   <= acc_d;
         carry_q <= carry_d;
         ill_q   <= ill_d;
`ifdef FBCPU_DIV_EN
         div0_q  <= div0_d;
`endif
      end
   end

endmodule

// File: doc/fbcpu_core_v2.md
Name: fbcpu_core_v2

Overview:
Parametrised second-generation accumulator CPU core for the FB-CPU family. It uses the same single-port RAM interface (MAR/MDRIn/MDROut/RAMWr) and the same 4-bit-opcode instruction format. It adds widened operand/address widths, carry-based and sign-based branches, logic ops, immediate load, a proper HALT/resume state, and illegal-opcode and divide-by-zero detection. It sits between the RAM model and the top-level testbench/SoC wrapper.

Parameters:
ADDRESS_WIDTH, 6, RAM address and PC width; IR operand field = IR[ADDRESS_WIDTH-1:0]
DATA_WIDTH, 10, RAM word, IR and ACC width; must equal ADDRESS_WIDTH+4; opcode = IR[DATA_WIDTH-1:DATA_WIDTH-4]

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  resume pulse; sampled only in HALT state
MDROut  input  DATA_WIDTH  RAM read data; valid the cycle after MAR is presented with RAMWr=0
MAR  output  ADDRESS_WIDTH  RAM address (combinational from state/PC/IR)
MDRIn  output  DATA_WIDTH  RAM write data
RAMWr  output  1  RAM write strobe, one cycle per STORE
PC  output  ADDRESS_WIDTH  program counter (registered)
ACC  output  DATA_WIDTH  accumulator (registered)
carry  output  1  carry/borrow flag (registered)
halted  output  1  high while in HALT state
illegal  output  1  sticky: illegal opcode executed
div0  output  1  sticky: division by zero executed

Behaviour:
- Reset (async, any state, including mid-instruction): state=FETCH, PC=0, IR=0, ACC=0, carry=0, halted=0, illegal=0, div0=0. MAR=0, MDRIn=0, RAMWr=0 while rst is high. Core begins fetching at address 0 on the first clock after rst deasserts.
- Default output values in every state unless overridden: MAR=0, MDRIn=0, RAMWr=0.
- States:
  - FETCH: MAR=PC -> LATCH.
  - LATCH: IR<=MDROut; PC<=PC+1, wraps modulo 2^ADDRESS_WIDTH -> DECODE.
  - DECODE: dispatch on the opcode:
    - 0 LOAD, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 10 AND, 11 OR: MAR=operand -> EXEC.
    - 1 STORE: MAR=operand, MDRIn=ACC, RAMWr=1 -> FETCH.
    - 6 JMP: PC<=operand. 7 JZ: if ACC==0, PC<=operand. 12 JC: if carry, PC<=operand. 13 JN: if ACC MSB set, PC<=operand. All -> FETCH.
    - 8 NOP -> FETCH.
    - 9 HALT -> HALT.
    - 14 LDI: ACC<=zero-extended operand -> FETCH.
    - 15: illegal<=1 -> HALT.
  - EXEC: operate with MDROut, then -> FETCH:
    - LOAD: ACC=M.
    - ADD: {carry,ACC}=ACC+M.
    - SUB: ACC=ACC-M mod 2^DATA_WIDTH; carry=1 iff ACC<M (borrow).
    - MUL: ACC=low DATA_WIDTH bits of the product; carry unchanged.
    - DIV: unsigned quotient; if M==0, ACC=all ones and div0<=1, and execution continues.
    - AND/OR: bitwise.
    - Only ADD and SUB write carry.
  - HALT: halted=1, no RAM access, PC/ACC hold. start=1 -> FETCH at the current PC (the instruction after HALT). illegal/div0 are cleared only by rst.
- Cycle counts:
  - LOAD/ALU: 4 cycles.
  - STORE, jumps, NOP, LDI: 3 cycles.
  - HALT: 3 cycles to enter the HALT state.

Optional Feature:
FBCPU_DIV_EN. Defined: opcode 5 performs DIV as above. Undefined: no divider is synthesised; opcode 5 is handled as illegal (illegal<=1 -> HALT). The div0 port remains and is tied to 0.

Test Plan:
- Async reset mid-EXEC: assert rst between clock edges during LOAD -> PC=0, ACC=0, MAR=0 immediately, before the next edge. Fetch of address 0 begins after release.
- mem[0]=LDI 5 (0x385), mem[1]=ADD 20 (0x094), mem[20]=1023, mem[2]=JC 8 (0x308) -> ACC=4, carry=1, PC=8 after the 11th cycle.
- ACC=7, STORE 30 (0x05E) -> RAMWr high for exactly one cycle with MAR=30, MDRIn=7. Then mem[30]=7.
- ACC=100, DIV 21 (0x155) with mem[21]=0 -> ACC=1023, div0=1, next instruction fetched. Without FBCPU_DIV_EN -> illegal=1, halted=1.
- HALT (0x240) at address 3 -> halted=1, PC=4, RAMWr=0 for 20 idle cycles. One-cycle start pulse -> halted=0, MAR=4 next cycle.
- Opcode 15 (0x3C0) -> illegal=1, halted=1. Separately, NOP at address 63 -> PC wraps to 0 and fetches mem[0].
